ps2_key_event_decoder: RTL

//   Parametrised successor to the single-register PS/2 keypress decoder. Takes the

---
 rtl/ps2_key_event_decoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_event_decoder.sv
// PS/2 byte-stream decoder: make/break, E0-extended and E1 (Pause) events into a FWFT FIFO.
// Define PS2_DECODE_TIMEOUT_EN to build the prefix watchdog (TIMEOUT_CYCLES).
module ps2_key_event_decoder #(
  parameter int DEPTH          = 16,
  parameter int PAUSE_SKIP     = 7,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_done_tick,
  input  logic [7:0]               scan_data,
  input  logic                     ev_ready,
  input  logic                     clr_overflow,
  output logic                     ev_valid,
  output logic                     ev_make,
  output logic                     ev_ext,
  output logic [7:0]               ev_code,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow
);
  // state   | meaning
  // IDLE    | waiting for a code or prefix
  // BRK     | F0 seen, next code is a release
  // EXT     | E0 seen, next code is extended
  // EXT_BRK | E0 F0 seen, next code is an extended release
  // PAUSE   | E1 seen, swallowing the rest of the Pause sequence
  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SKW = $clog2(PAUSE_SKIP + 1) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t           r_state, w_state_nxt;
  logic [SKW-1:0]   r_skip;
  logic [9:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_is_e0, w_is_e1, w_is_f0, w_is_ack, w_special;
  logic             w_push, w_push_make, w_push_ext, w_skip_load, w_pause_last;
  logic [7:0]       w_push_code;
  logic             w_timeout, w_full, w_pop, w_write;

  assign w_is_e0      = (scan_data == 8'hE0);
  assign w_is_e1      = (scan_data == 8'hE1);
  assign w_is_f0      = (scan_data == 8'hF0);
  assign w_is_ack     = (scan_data == 8'hFA) || (scan_data == 8'hAA);
  assign w_special    = w_is_e0 || w_is_e1 || w_is_f0;
  assign w_pause_last = (r_skip <= SKW'(1));

`ifdef PS2_DECODE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge clk) begin
    if (reset || scan_done_tick || r_state == S_IDLE) r_tmo_cnt <= TW'(TIMEOUT_CYCLES);
    else if (r_tmo_cnt != '0)                          r_tmo_cnt <= r_tmo_cnt - 1'b1;
  end

  assign w_timeout = (r_state != S_IDLE) && !scan_done_tick && (r_tmo_cnt == '0);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (scan_done_tick) begin
      case (r_state)
        S_IDLE:  w_state_nxt = w_is_e0 ? S_EXT : w_is_f0 ? S_BRK : w_is_e1 ? S_PAUSE : S_IDLE;
        S_EXT:   w_state_nxt = w_is_f0 ? S_EXT_BRK : w_is_e0 ? S_EXT : w_is_e1 ? S_PAUSE : S_IDLE;
        S_PAUSE: w_state_nxt = w_pause_last ? S_IDLE : S_PAUSE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_push      = 1'b0;
    w_push_make = 1'b1;
    w_push_ext  = 1'b0;
    w_push_code = scan_data;
    w_skip_load = 1'b0;
    if (scan_done_tick) begin
      case (r_state)
        S_IDLE: begin
          w_skip_load = w_is_e1;
          w_push      = !w_special && !w_is_ack;
        end
        S_BRK: begin
          w_push      = !w_special;
          w_push_make = 1'b0;
        end
        S_EXT: begin
          w_skip_load = w_is_e1;
          w_push      = !w_special;
          w_push_ext  = 1'b1;
        end
        S_EXT_BRK: begin
          w_push      = !w_special;
          w_push_make = 1'b0;
          w_push_ext  = 1'b1;
        end
        S_PAUSE: begin
          w_push      = w_pause_last;
          w_push_code = 8'hE1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                            r_skip <= '0;
    else if (w_skip_load)                                 r_skip <= SKW'(PAUSE_SKIP);
    else if (w_timeout)                                   r_skip <= '0;
    else if (scan_done_tick && r_state == S_PAUSE && r_skip != '0) r_skip <= r_skip - 1'b1;
  end

  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = (r_count != '0) && ev_ready;
  assign w_write = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {w_push_make, w_push_ext, w_push_code};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_write && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_write) r_count <= r_count - 1'b1;
      if (w_push && !w_write)     r_overflow <= 1'b1;
      else if (clr_overflow)      r_overflow <= 1'b0;
    end
  end

  assign ev_valid = (r_count != '0);
  assign ev_make  = r_mem[r_rd_ptr][9];
  assign ev_ext   = r_mem[r_rd_ptr][8];
  assign ev_code  = r_mem[r_rd_ptr][7:0];
  assign ev_count = r_count;
  assign overflow = r_overflow;
endmodule
